// File: rtl/ldpc_sched_pkg.sv
// Shared definitions for the NB-LDPC decode sequencer: state encoding and
// default code dimensions used by both the scheduler and the datapath.
package ldpc_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CNU  = 3'd2,
      ST_SYN  = 3'd3,
      ST_OUT  = 3'd4,
      ST_FIN  = 3'd5
   } state_t;

   localparam int DEF_N_COLS   = 48;
   localparam int DEF_N_ROWS   = 24;
   localparam int DEF_DC       = 4;
   localparam int DEF_MAX_ITER = 10;

endpackage

// File: rtl/sched_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that
// reports when the count equals a caller-supplied terminal value.
module sched_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] terminal,
   output logic [WIDTH-1:0] count,
   output logic             at_terminal
);

   // NOTE: sequential state uses <= so every counter samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign at_terminal = (count == terminal);

endmodule

// File: rtl/ldpc_iter_scheduler.sv
// Decode sequencer: LOAD -> (CNU sweep -> SYN)* -> OUT -> FIN, with early exit
// on a zero syndrome and a hard stop after MAX_ITER iterations.
module ldpc_iter_scheduler
   import ldpc_sched_pkg::*;
#(
   parameter int N_COLS   = DEF_N_COLS,
   parameter int N_ROWS   = DEF_N_ROWS,
   parameter int DC       = DEF_DC,
   parameter int MAX_ITER = DEF_MAX_ITER,
   parameter int ADDR_W   = 13,
   parameter int EDGE_W   = 2,
   parameter int ITER_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              llr_valid,
   input  logic              syn_valid,
   input  logic              syn_zero,
   input  logic              out_ready,
   output logic              load_en,
   output logic [ADDR_W-1:0] load_addr,
   output logic              cnu_en,
   output logic [ADDR_W-1:0] row_addr,
   output logic [EDGE_W-1:0] edge_idx,
   output logic              syn_start,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ITER_W-1:0] iter_count,
   output logic              busy,
   output logic              done,
   output logic              converged
);

   localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(N_COLS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(N_ROWS - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(DC - 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

   state_t state;
   logic   syn_first;

   logic              st_idle, st_load, st_cnu, st_syn, st_out, st_fin;
   logic              accept_start;
   logic [ADDR_W-1:0] col_count, row_count;
   logic [EDGE_W-1:0] edge_count;
   logic              col_last, row_last, edge_last, iter_last;
   logic              load_beat, out_beat;

   assign st_idle = (state == ST_IDLE);
   assign st_load = (state == ST_LOAD);
   assign st_cnu  = (state == ST_CNU);
   assign st_syn  = (state == ST_SYN);
   assign st_out  = (state == ST_OUT);
   assign st_fin  = (state == ST_FIN);

   assign accept_start = st_idle && start;
   assign load_beat    = st_load && llr_valid;
   assign out_beat     = st_out && out_ready;

   // One column counter serves both the load and output sweeps.
   sched_counter #(.WIDTH(ADDR_W)) u_col (
      .clk         (clk),
      .reset       (reset),
      .clr         (accept_start || ((load_beat || out_beat) && col_last)),
      .en          (load_beat || out_beat),
      .terminal    (COL_LAST),
      .count       (col_count),
      .at_terminal (col_last)
   );

   sched_counter #(.WIDTH(EDGE_W)) u_edge (
      .clk         (clk),
      .reset       (reset),
      .clr         (accept_start || (st_cnu && edge_last)),
      .en          (st_cnu),
      .terminal    (EDGE_LAST),
      .count       (edge_count),
      .at_terminal (edge_last)
   );

   sched_counter #(.WIDTH(ADDR_W)) u_row (
      .clk         (clk),
      .reset       (reset),
      .clr         (accept_start || (st_cnu && edge_last && row_last)),
      .en          (st_cnu && edge_last),
      .terminal    (ROW_LAST),
      .count       (row_count),
      .at_terminal (row_last)
   );

   // iter_last flags the final permitted iteration; the count itself may
   // step once more to report MAX_ITER completed iterations.
   sched_counter #(.WIDTH(ITER_W)) u_iter (
      .clk         (clk),
      .reset       (reset),
      .clr         (accept_start),
      .en          (st_syn && syn_valid),
      .terminal    (ITER_LAST),
      .count       (iter_count),
      .at_terminal (iter_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         converged <= 1'b0;
         syn_first <= 1'b0;
      end else begin
         syn_first <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  converged <= 1'b0;
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (llr_valid && col_last)
                  state <= ST_CNU;
            end
            ST_CNU: begin
               if (edge_last && row_last) begin
                  syn_first <= 1'b1;
                  state     <= ST_SYN;
               end
            end
            ST_SYN: begin
               if (syn_valid) begin
                  if (syn_zero) begin
                     converged <= 1'b1;
                     state     <= ST_OUT;
                  end else if (iter_last) begin
                     converged <= 1'b0;
                     state     <= ST_OUT;
                  end else begin
                     state <= ST_CNU;
                  end
               end
            end
            ST_OUT: begin
               if (out_ready && col_last)
                  state <= ST_FIN;
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Addresses are forced to zero outside their phase so idle outputs stay quiet.
   assign load_en   = load_beat;
   assign load_addr = st_load ? col_count : '0;
   assign cnu_en    = st_cnu;
   assign row_addr  = st_cnu ? row_count : '0;
   assign edge_idx  = st_cnu ? edge_count : '0;
   assign syn_start = st_syn && syn_first;
   assign out_valid = st_out;
   assign out_addr  = st_out ? col_count : '0;
   assign busy      = !st_idle;
   assign done      = st_fin;

endmodule
